bus_decoder_n: RTL
==================

Name: bus_decoder_n

Overview:
Parametrised one-master to N-slave bus decoder. It is the successor to the fixed two-slave D-bus/I-bus interconnects. Address decode uses per-slave base/mask pairs. Transactions are registered and tracked by a small FSM. Illegal addresses and hung slaves get an in-band bus-error response, so the core sees a fault instead of the bench only raising an assertion.

Parameters:
N_SLAVES, 2, number of slave ports (1..16)
SLV_BASE, {32'h2000_0000, 32'h0000_0000}, packed N_SLAVES x 32 base addresses; slice i belongs to slave i
SLV_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, packed N_SLAVES x 32 decode masks
TIMEOUT_CYCLES, 16, max cycles waiting for slave done; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_bstart  in  1  master transaction start pulse
m_addr  in  32  master address
m_ttype  in  1  READ=0, WRITE=1
m_tsize  in  2  BYTE=0, HALFWORD=1, WORD=2
m_wdata  in  32  write data
m_rdata  out  32  read data returned to master
m_bdone  out  1  one-cycle completion pulse
m_berr  out  1  bus error, valid with m_bdone
s_ss  out  N_SLAVES  per-slave select, held for the whole transaction
s_bstart  out  N_SLAVES  per-slave start pulse
s_addr  out  32  latched address, broadcast to all slaves
s_ttype  out  1  latched ttype, broadcast
s_tsize  out  2  latched tsize, broadcast
s_wdata  out  32  latched wdata, broadcast
s_rdata  in  N_SLAVES*32  packed slave read data
s_bdone  in  N_SLAVES  per-slave done pulse

Behaviour:
- Reset (async assert, sync release): every output is 0, FSM is IDLE, timeout counter is 0, selected index is 0.
- Decode: slave i matches when (addr & SLV_MASK[i]) == SLV_BASE[i]. On overlapping matches the lowest index wins.
- States are IDLE, REQ, WAIT and ERR.
- IDLE: m_bstart=1 latches addr/ttype/tsize/wdata and the decode result.
  - Match: go to REQ.
  - No match: go to ERR.
- REQ (1 cycle):
  - s_bstart[sel]=1 and s_ss[sel]=1.
  - Counter cleared; go to WAIT.
- WAIT:
  - s_ss[sel] stays 1; the counter increments each cycle.
  - On s_bdone[sel]=1: latch s_rdata[sel]; next cycle m_bdone=1, m_berr=0; go to IDLE.
  - On counter == TIMEOUT_CYCLES-1 with no done: drop s_ss; next cycle m_bdone=1, m_berr=1, m_rdata=0; go to IDLE.
  - If done and timeout expiry fall in the same cycle, done wins.
- ERR (1 cycle): m_bdone=1, m_berr=1, m_rdata=0; go to IDLE.
- Latency from the m_bstart cycle T:
  - Hit: s_bstart at T+1; m_bdone one cycle after the slave's s_bdone.
  - Miss: m_bdone at T+2.
- m_bdone, m_berr and m_rdata are registered. m_rdata holds its value until the next m_bdone.
- s_bdone from non-selected slaves, or outside WAIT, is ignored. A late done from a timed-out slave is ignored.
- m_bstart outside IDLE is ignored and the transaction is not queued.
- s_ss is one-hot or zero at all times. Non-selected s_bstart/s_ss bits are 0.
- s_* broadcast signals hold their latched values between transactions.
- Reset asserted mid-transaction aborts the transaction with no m_bdone and clears all selects immediately.

Optional Feature:
BUS_DECODER_ERR_LOG_EN
- Defined: adds outputs err_valid (1), err_addr (32), err_code (1: 0=decode miss, 1=timeout) and err_count (8, saturating at 255), plus input err_clr (1).
  - The first error after reset or after err_clr sets err_valid and captures addr and code; later errors only increment err_count.
  - err_clr=1 clears all four in the next cycle. If an error coincides with err_clr, the clear wins and the error is dropped.
  - All four reset to 0.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Read hit: WORD read at 0x2000_0010, slave1 returns 0xCAFEBABE with s_bdone 3 cycles after s_bstart -> s_bstart[1] at T+1, s_ss=2'b10 until done, m_bdone one cycle after s_bdone, m_rdata=0xCAFEBABE, m_berr=0.
- Write broadcast: BYTE write at 0x0000_0004, wdata 0x000000A5 -> s_addr=0x4, s_ttype=1, s_tsize=0, s_wdata=0xA5 at T+1, s_ss=2'b01, m_berr=0 on done.
- Decode miss: read at 0x4000_0000 -> no s_ss/s_bstart activity, m_bdone=1 with m_berr=1 and m_rdata=0 at T+2.
- Timeout: slave0 never asserts done, TIMEOUT_CYCLES=16 -> s_ss[0] drops after 16 WAIT cycles, then m_bdone=1 with m_berr=1; a later s_bdone[0] produces no second m_bdone.
- Edge cases:
  - Done on the same cycle as the counter reaches 15 -> m_berr=0 with data returned.
  - m_bstart during WAIT -> ignored.
  - rst_n low during WAIT -> s_ss=0 immediately, no m_bdone.
- Error log (macro defined):
  - Miss at 0x4000_0000 then a timeout at 0x0000_0008 -> err_addr=0x4000_0000, err_code=0, err_count=2.
  - err_clr -> all four outputs read 0 the next cycle.

Source files
------------

// File: rtl/bus_decoder_n.sv
// One-master to N-slave bus decoder with base/mask decode, a REQ/WAIT FSM and in-band bus errors.
// Optional error log enabled by defining BUS_DECODER_ERR_LOG_EN.
module bus_decoder_n #(
  parameter int                      N_SLAVES       = 2,
  parameter logic [N_SLAVES*32-1:0]  SLV_BASE       = {32'h2000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]  SLV_MASK       = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                      TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_bstart,
  input  logic [31:0]            m_addr,
  input  logic                   m_ttype,
  input  logic [1:0]             m_tsize,
  input  logic [31:0]            m_wdata,
  output logic [31:0]            m_rdata,
  output logic                   m_bdone,
  output logic                   m_berr,
  output logic [N_SLAVES-1:0]    s_ss,
  output logic [N_SLAVES-1:0]    s_bstart,
  output logic [31:0]            s_addr,
  output logic                   s_ttype,
  output logic [1:0]             s_tsize,
  output logic [31:0]            s_wdata,
`ifdef BUS_DECODER_ERR_LOG_EN
  input  logic                   err_clr,
  output logic                   err_valid,
  output logic [31:0]            err_addr,
  output logic                   err_code,
  output logic [7:0]             err_count,
`endif
  input  logic [N_SLAVES*32-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]    s_bdone
);

  localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic               ttype_q, ttype_d;
  logic [1:0]         tsize_q, tsize_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               bdone_q, bdone_d;
  logic               berr_q, berr_d;

  logic               dec_hit;
  logic [SEL_W-1:0]   dec_idx;
  logic               sel_done;
  logic [31:0]        sel_rdata;
  logic               timeout_hit;

  // Scanning from the top index down lets the lowest matching slave win on overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    sel_done  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_done  = s_bdone[i];
        sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (m_bstart) state_d = dec_hit ? S_REQ : S_ERR;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (sel_done || timeout_hit) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Done is tested before the timeout, so a simultaneous done still returns data.
  always_comb begin
    s_ss     = '0;
    s_bstart = '0;
    sel_d    = sel_q;
    addr_d   = addr_q;
    ttype_d  = ttype_q;
    tsize_d  = tsize_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    bdone_d  = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m_bstart) begin
          sel_d   = dec_idx;
          addr_d  = m_addr;
          ttype_d = m_ttype;
          tsize_d = m_tsize;
          wdata_d = m_wdata;
        end
      end
      S_REQ: begin
        s_bstart[sel_q] = 1'b1;
        s_ss[sel_q]     = 1'b1;
        cnt_d           = '0;
      end
      S_WAIT: begin
        s_ss[sel_q] = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (sel_done) begin
          rdata_d = sel_rdata;
          bdone_d = 1'b1;
        end else if (timeout_hit) begin
          rdata_d = '0;
          bdone_d = 1'b1;
          berr_d  = 1'b1;
        end
      end
      S_ERR: begin
        rdata_d = '0;
        bdone_d = 1'b1;
        berr_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      ttype_q <= 1'b0;
      tsize_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      bdone_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      ttype_q <= ttype_d;
      tsize_q <= tsize_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      bdone_q <= bdone_d;
      berr_q  <= berr_d;
    end
  end

  assign m_rdata = rdata_q;
  assign m_bdone = bdone_q;
  assign m_berr  = berr_q;
  assign s_addr  = addr_q;
  assign s_ttype = ttype_q;
  assign s_tsize = tsize_q;
  assign s_wdata = wdata_q;

`ifdef BUS_DECODER_ERR_LOG_EN
  logic        log_err, log_code;
  logic        err_valid_q;
  logic [31:0] err_addr_q;
  logic        err_code_q;
  logic [7:0]  err_count_q;

  assign log_err  = (state_q == S_ERR) || ((state_q == S_WAIT) && !sel_done && timeout_hit);
  assign log_code = (state_q == S_WAIT);

  // Clear has priority, so an error landing in the clear cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_code_q  <= 1'b0;
      err_count_q <= '0;
    end else if (err_clr) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_code_q  <= 1'b0;
      err_count_q <= '0;
    end else if (log_err) begin
      if (!err_valid_q) begin
        err_valid_q <= 1'b1;
        err_addr_q  <= addr_q;
        err_code_q  <= log_code;
      end
      if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;
`endif

endmodule
